// File: rtl/render_pkg.sv
// Shared definitions for the frame sequencer and the pixel render engine.
// Latency: n/a (constants and pure field helpers only).
// Backpressure: n/a.
package render_pkg;

    // Frame sequencer state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_ISSUE = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Sprite entry layout (32-bit entry), shared with the render engine
    localparam int SPR_ENTRY_W = 32;
    localparam int SPR_EN_BIT  = 31;
    localparam int SPR_X_LSB   = 0;
    localparam int SPR_X_W     = 10;
    localparam int SPR_Y_LSB   = 10;
    localparam int SPR_Y_W     = 9;
    localparam int SPR_ID_LSB  = 19;
    localparam int SPR_ID_W    = 6;
    localparam int SPR_PAL_LSB = 25;
    localparam int SPR_PAL_W   = 4;

    function automatic logic spr_enabled(input logic [SPR_ENTRY_W-1:0] e);
        return e[SPR_EN_BIT];
    endfunction

    function automatic logic [SPR_X_W-1:0] spr_x(input logic [SPR_ENTRY_W-1:0] e);
        return e[SPR_X_LSB +: SPR_X_W];
    endfunction

    function automatic logic [SPR_Y_W-1:0] spr_y(input logic [SPR_ENTRY_W-1:0] e);
        return e[SPR_Y_LSB +: SPR_Y_W];
    endfunction

    function automatic logic [SPR_ID_W-1:0] spr_id(input logic [SPR_ENTRY_W-1:0] e);
        return e[SPR_ID_LSB +: SPR_ID_W];
    endfunction

    function automatic logic [SPR_PAL_W-1:0] spr_pal(input logic [SPR_ENTRY_W-1:0] e);
        return e[SPR_PAL_LSB +: SPR_PAL_W];
    endfunction

endpackage

// File: rtl/frame_clear_gen.sv
// Framebuffer clear address generator: walks 0..CLR_WORDS-1 once per start pulse.
// Latency: clr_valid rises the cycle after start; one word per cycle with clr_ready high.
// Backpressure: clr_addr holds while clr_ready is low; last pulses on the final acceptance.
module frame_clear_gen #(
    parameter int CLR_WORDS = 4800,
    parameter int CLR_AW    = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clr_ready,
    output logic              clr_valid,
    output logic [CLR_AW-1:0] clr_addr,
    output logic              last
);

    localparam logic [CLR_AW-1:0] LAST_ADDR = CLR_AW'(CLR_WORDS - 1);
    localparam logic [CLR_AW-1:0] ADDR_ONE  = CLR_AW'(1);

    logic active;

    // Run flag and address counter; address returns to 0 after the final word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            clr_addr <= '0;
        end else if (start) begin
            active   <= 1'b1;
            clr_addr <= '0;
        end else if (active && clr_ready) begin
            if (clr_addr == LAST_ADDR) begin
                active   <= 1'b0;
                clr_addr <= '0;
            end else begin
                clr_addr <= clr_addr + ADDR_ONE;
            end
        end
    end

    // Request and end-of-pass indication
    always_comb begin
        clr_valid = active;
        last      = active && clr_ready && (clr_addr == LAST_ADDR);
    end

endmodule

// File: rtl/frame_render_ctrl.sv
// Per-frame sequencer: on vsync fall, optional clear, then one draw command per enabled sprite.
// Latency: 3 cycles per enabled sprite minimum (fetch/load/issue), 2 per skipped sprite.
// Backpressure: cmd_valid/cmd_data held until cmd_ready; clear stalls on clr_ready; drain on eng_busy.
// Build option: define FRAME_CLEAR_EN to include the framebuffer clear pass.
module frame_render_ctrl #(
    parameter int MAX_SPR   = 16,
    parameter int SPR_AW    = 4,
    parameter int SPR_DW    = 32,
    parameter int CLR_WORDS = 4800,
    parameter int CLR_AW    = 13
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              vs_in,
    input  logic [SPR_AW:0]   spr_count,
    output logic [SPR_AW-1:0] tbl_addr,
    input  logic [SPR_DW-1:0] tbl_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [SPR_DW-1:0] cmd_data,
    input  logic              eng_busy,
    output logic              clr_valid,
    input  logic              clr_ready,
    output logic [CLR_AW-1:0] clr_addr,
    input  logic              ovr_clr,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    import render_pkg::*;

    localparam logic [SPR_AW:0]   MAX_N   = (SPR_AW+1)'(MAX_SPR);
    localparam logic [SPR_AW:0]   N_ONE   = (SPR_AW+1)'(1);
    localparam logic [SPR_AW-1:0] IDX_ONE = SPR_AW'(1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              vs_q;
    logic              trig;
    logic [SPR_AW:0]   n_q;
    logic [SPR_AW:0]   n_new;
    logic [SPR_AW-1:0] idx;
    logic              last_idx;
    logic              spr_en;
    logic              step_idx;

    // Frame trigger, clamped count and per-entry decode
    always_comb begin
        trig     = vs_q & ~vs_in;
        n_new    = (spr_count > MAX_N) ? MAX_N : spr_count;
        // n_q >= 1 whenever this is consulted, so the subtraction cannot underflow in use
        last_idx = ({1'b0, idx} == (n_q - N_ONE));
        spr_en   = tbl_data[SPR_DW-1];
        step_idx = ((state == ST_LOAD) && !spr_en) || ((state == ST_ISSUE) && cmd_ready);
    end

`ifdef FRAME_CLEAR_EN
    logic clr_start;
    logic clr_last;

    assign clr_start = (state == ST_IDLE) && trig;

    frame_clear_gen #(
        .CLR_WORDS (CLR_WORDS),
        .CLR_AW    (CLR_AW)
    ) u_clear (
        .clk       (clk),
        .rst_n     (RSTN),
        .start     (clr_start),
        .clr_ready (clr_ready),
        .clr_valid (clr_valid),
        .clr_addr  (clr_addr),
        .last      (clr_last)
    );
`else
    localparam int unused_clr_words = CLR_WORDS;
    logic unused_clr_ready;

    assign unused_clr_ready = clr_ready;
    assign clr_valid        = 1'b0;
    assign clr_addr         = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (trig) begin
`ifdef FRAME_CLEAR_EN
                    state_nxt = ST_CLEAR;
`else
                    state_nxt = (n_new == '0) ? ST_DRAIN : ST_FETCH;
`endif
                end
            end
`ifdef FRAME_CLEAR_EN
            ST_CLEAR: begin
                if (clr_last) begin
                    state_nxt = (n_q == '0) ? ST_DRAIN : ST_FETCH;
                end
            end
`endif
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (spr_en) begin
                    state_nxt = ST_ISSUE;
                end else begin
                    state_nxt = last_idx ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_nxt = last_idx ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (!eng_busy) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DONE);
        tbl_addr   = (state == ST_FETCH) ? idx : '0;
    end

    // Vsync edge detector; idles high so a held-low vsync at reset release is not a trigger
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= vs_in;
        end
    end

    // Sprite count latch and entry index; index stops at the last entry instead of wrapping
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            n_q <= '0;
            idx <= '0;
        end else if ((state == ST_IDLE) && trig) begin
            n_q <= n_new;
            idx <= '0;
        end else if (step_idx && !last_idx) begin
            idx <= idx + IDX_ONE;
        end
    end

    // Draw command register, held stable across backpressure
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
        end else if ((state == ST_LOAD) && spr_en) begin
            cmd_valid <= 1'b1;
            cmd_data  <= tbl_data;
        end else if ((state == ST_ISSUE) && cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    // Sticky overrun: a trigger outside IDLE (including DONE) is dropped and flagged; set beats clear
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            overrun <= 1'b0;
        end else if (trig && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_render_ctrl.sv
// Bench for frame_render_ctrl: vector table, directed corner sequences, randomized frames.
// Expected command streams come from a list-level model: enabled entries among the first min(count,16).
// Clear-pass checks are compiled only when FRAME_CLEAR_EN is defined.
module tb_frame_render_ctrl;

    localparam int MAX_SPR   = 16;
    localparam int SPR_AW    = 4;
    localparam int SPR_DW    = 32;
    localparam int CLR_WORDS = 8;
    localparam int CLR_AW    = 3;
`ifdef FRAME_CLEAR_EN
    localparam int CLR_LAT = CLR_WORDS;
`else
    localparam int CLR_LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              RSTN;
    logic              vs_in;
    logic [SPR_AW:0]   spr_count;
    logic [SPR_AW-1:0] tbl_addr;
    logic [SPR_DW-1:0] tbl_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [SPR_DW-1:0] cmd_data;
    logic              eng_busy;
    logic              clr_valid;
    logic              clr_ready;
    logic [CLR_AW-1:0] clr_addr;
    logic              ovr_clr;
    logic              busy;
    logic              frame_done;
    logic              overrun;

    frame_render_ctrl #(
        .MAX_SPR(MAX_SPR), .SPR_AW(SPR_AW), .SPR_DW(SPR_DW),
        .CLR_WORDS(CLR_WORDS), .CLR_AW(CLR_AW)
    ) dut (
        .clk(clk), .RSTN(RSTN), .vs_in(vs_in), .spr_count(spr_count),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_data(cmd_data), .eng_busy(eng_busy),
        .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_addr(clr_addr),
        .ovr_clr(ovr_clr), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Sprite table with one-cycle synchronous read
    logic [SPR_DW-1:0] tbl [MAX_SPR];
    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    // Environment drivers: ready/busy modes, updated shortly after each rising edge
    int cyc        = 0;
    int busy_until = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    int clr_mode   = 0;   // 0: always ready, 1: random
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #2;
            case (ready_mode)
                0:       cmd_ready = 1'b1;
                1:       cmd_ready = 1'($urandom_range(0, 1));
                default: cmd_ready = 1'b0;
            endcase
            clr_ready = (clr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            eng_busy  = (cyc < busy_until);
        end
    end

    // Monitor: accepted commands, accepted clear words, frame_done pulses
    logic [SPR_DW-1:0] got_q[$];
    logic [CLR_AW-1:0] clr_q[$];
    int done_cnt       = 0;
    int cmd_during_clr = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) got_q.push_back(cmd_data);
            if (clr_valid && clr_ready) clr_q.push_back(clr_addr);
            if (frame_done) done_cnt = done_cnt + 1;
            if (cmd_valid && clr_valid) cmd_during_clr = cmd_during_clr + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int last_done_cyc = 0;
    logic [SPR_DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk  = n_chk + 1;
        n_fail = n_fail + 1;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic fill_table(input logic [MAX_SPR-1:0] mask);
        logic [31:0] r;
        for (int i = 0; i < MAX_SPR; i++) begin
            r = $urandom;
            tbl[i] = {mask[i], r[30:0]};
        end
    endtask

    // Reference: every enabled entry among the first min(count, MAX_SPR), in table order
    task automatic build_exp(input int cnt);
        int n;
        exp_q.delete();
        n = (cnt > MAX_SPR) ? MAX_SPR : cnt;
        for (int i = 0; i < n; i++) begin
            if (tbl[i][SPR_DW-1]) exp_q.push_back(tbl[i]);
        end
    endtask

    task automatic trigger(input int cnt);
        logic [31:0] c;
        c = cnt;
        @(negedge clk);
        spr_count = c[SPR_AW:0];
        vs_in = 1'b0;
        @(negedge clk);
        vs_in = 1'b1;
    endtask

    // Counts rising edges after the trigger until frame_done is seen
    task automatic wait_done(input string name, input int budget, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                ok = 1'b1;
                lat = k + 1;
                last_done_cyc = cyc;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_cmd_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic check_frame(input string tag, input int cnt, input int q0, input int d0);
        @(negedge clk);
        @(negedge clk);
        build_exp(cnt);
        chk({tag, "_ncmd"}, got_q.size() - q0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (q0 + i < got_q.size()) chk({tag, "_data"}, got_q[q0 + i], exp_q[i]);
        end
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic run_frame(input string tag, input int cnt, input int busy_cyc, output int lat);
        int q0;
        int d0;
        q0 = got_q.size();
        d0 = done_cnt;
        @(negedge clk);
        busy_until = cyc + 1 + busy_cyc;
        trigger(cnt);
        wait_done({tag, "_done_wait"}, 3000, lat);
        if (busy_cyc > 0) chk({tag, "_done_after_busy"}, 32'(last_done_cyc >= busy_until), 1);
        check_frame(tag, cnt, q0, d0);
    endtask

    typedef struct {
        int              cnt;
        logic [15:0]     mask;
        int              exp_ncmd;
        int              rdy_mode;
        int              busy_cyc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat;
        int q0;
        int d0;
        int c0;
        int rc;
        logic [31:0] rm;

        vecs[0] = '{3,  16'hFFFF, 3,  0, 0};
        vecs[1] = '{3,  16'hFFFD, 2,  0, 3};
        vecs[2] = '{20, 16'hFFFF, 16, 0, 0};
        vecs[3] = '{0,  16'hFFFF, 0,  0, 12};
        vecs[4] = '{16, 16'h0000, 0,  1, 0};
        vecs[5] = '{5,  16'h8421, 1,  1, 4};
        vecs[6] = '{16, 16'hAAAA, 8,  1, 0};
        vecs[7] = '{15, 16'h8000, 0,  0, 0};
        vecs[8] = '{16, 16'h8000, 1,  1, 6};
        vecs[9] = '{1,  16'h0001, 1,  0, 0};

        // Reset held, then released with vsync idle high
        RSTN = 1'b0; vs_in = 1'b1; spr_count = '0; ovr_clr = 1'b0;
        fill_table(16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_tbl_addr", tbl_addr, 0);
        chk("rst_clr_valid", clr_valid, 0);
        chk("rst_clr_addr", clr_addr, 0);
        @(negedge clk);
        RSTN = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_cmd_valid", cmd_valid, 0);
        chk("idle_done_cnt", done_cnt, 0);

        // Three enabled sprites, no stalls: 9 fetch/load/issue cycles + 1 drain, then DONE
        fill_table(16'hFFFF);
        ready_mode = 0;
        run_frame("lat3", 3, 0, lat);
        chk("lat3_latency", lat, 10 + CLR_LAT);

        // Vector table
        for (int v = 0; v < 10; v++) begin
            fill_table(vecs[v].mask);
            ready_mode = vecs[v].rdy_mode;
            q0 = got_q.size();
            run_frame($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].busy_cyc, lat);
            chk($sformatf("vec%0d_table_ncmd", v), got_q.size() - q0, vecs[v].exp_ncmd);
        end

        // Held backpressure: command stays put for 5 stalled cycles, skipped entry not issued
        fill_table(16'hFFFD);
        ready_mode = 2;
        q0 = got_q.size();
        d0 = done_cnt;
        busy_until = cyc;
        trigger(3);
        wait_cmd_valid("hold_wait_valid");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", cmd_valid, 1);
            chk("hold_data", cmd_data, tbl[0]);
        end
        ready_mode = 0;
        wait_done("hold_done_wait", 500, lat);
        check_frame("hold", 3, q0, d0);

        // Vsync edge while issuing: overrun set, frame still finishes once
        fill_table(16'hFFFF);
        ready_mode = 2;
        q0 = got_q.size();
        d0 = done_cnt;
        trigger(3);
        wait_cmd_valid("ovr_wait_valid");
        trigger(3);
        chk("ovr_set", overrun, 1);
        chk("ovr_busy", busy, 1);
        ready_mode = 0;
        wait_done("ovr_done_wait", 500, lat);
        check_frame("ovr", 3, q0, d0);
        chk("ovr_sticky", overrun, 1);
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // Set and clear in the same cycle: set wins
        ready_mode = 2;
        q0 = got_q.size();
        d0 = done_cnt;
        trigger(2);
        wait_cmd_valid("setwin_wait_valid");
        @(negedge clk); vs_in = 1'b0; ovr_clr = 1'b1;
        @(negedge clk); vs_in = 1'b1; ovr_clr = 1'b0;
        chk("setwin_overrun", overrun, 1);
        ready_mode = 0;
        wait_done("setwin_done_wait", 500, lat);
        check_frame("setwin", 2, q0, d0);
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;

        // Vsync edge landing in the DONE cycle: overrun, no new frame from that edge
        ready_mode = 0;
        trigger(2);
        wait_done("donetrig_wait", 500, lat);
        vs_in = 1'b0;
        @(posedge clk);
        #1;
        chk("donetrig_overrun", overrun, 1);
        chk("donetrig_idle", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("donetrig_no_restart", busy, 0);
        @(negedge clk); vs_in = 1'b1; ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        chk("donetrig_cleared", overrun, 0);
        run_frame("after_donetrig", 2, 0, lat);

        // Reset mid-frame: command drops immediately, no frame_done
        ready_mode = 2;
        trigger(4);
        wait_cmd_valid("midrst_wait_valid");
        @(negedge clk);
        d0 = done_cnt;
        RSTN = 1'b0;
        #1;
        chk("midrst_cmd_valid", cmd_valid, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        RSTN = 1'b1;
        ready_mode = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", busy, 0);

`ifdef FRAME_CLEAR_EN
        // Clear pass with random clr_ready: each address once, in order, before any command
        clr_mode = 1;
        c0 = clr_q.size();
        cmd_during_clr = 0;
        run_frame("clr", 3, 0, lat);
        chk("clr_nwords", clr_q.size() - c0, CLR_WORDS);
        for (int i = 0; i < CLR_WORDS; i++) begin
            if (c0 + i < clr_q.size()) chk("clr_addr_seq", clr_q[c0 + i], i);
        end
        chk("clr_no_overlap", cmd_during_clr, 0);

        // Reset during the clear pass
        clr_mode = 0;
        busy_until = cyc;
        trigger(3);
        @(posedge clk);
        #1;
        chk("clrrst_in_clear", clr_valid, 1);
        @(negedge clk);
        d0 = done_cnt;
        RSTN = 1'b0;
        #1;
        chk("clrrst_clr_valid", clr_valid, 0);
        chk("clrrst_busy", busy, 0);
        @(negedge clk);
        RSTN = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("clrrst_no_done", done_cnt - d0, 0);
        clr_mode = 1;
`else
        c0 = 0;
        chk("noclr_clr_valid", clr_valid, 0);
`endif

        // Randomized frames against the list model
        for (int r = 0; r < 12; r++) begin
            rc = $urandom_range(0, 20);
            rm = $urandom;
            fill_table(rm[MAX_SPR-1:0]);
            ready_mode = 1;
            run_frame($sformatf("rnd%0d", r), rc, $urandom_range(0, 15), lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
